// File: rtl/psg_write_sequencer.sv
// Purpose: arbitrates two requesters' AY-3-8910-style register writes and
// sequences them onto the bus of one or two PSG chips. Each write is an
// address-latch phase (skipped when the target chips already have that
// register latched) followed by a data-write phase. Phase timing counts clk_en
// ticks.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   clk_en               PSG clock enable; phase timing counts these ticks
//   req[1:0]             per-requester write request
//   reqN_cs/reg/data     requester N's target chips, register number and data
//   ack[1:0]             one-cycle capture pulse per requester
//   cache_clr            synchronous clear of both latched-address caches
//   psg_bdir, psg_bc1    PSG bus control (the integrator gates them with psg_cs)
//   psg_din              PSG data/address bus
//   psg_cs               chips addressed by the current transaction
//   busy                 high whenever the sequencer is not idle
module psg_write_sequencer #(
    parameter int unsigned PHASE_TICKS = 2,
    parameter int unsigned GAP_TICKS   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clk_en,
    input  logic [1:0] req,
    input  logic [1:0] req0_cs,
    input  logic [1:0] req1_cs,
    input  logic [3:0] req0_reg,
    input  logic [3:0] req1_reg,
    input  logic [7:0] req0_data,
    input  logic [7:0] req1_data,
    output logic [1:0] ack,
    input  logic       cache_clr,
    output logic       psg_bdir,
    output logic       psg_bc1,
    output logic [7:0] psg_din,
    output logic [1:0] psg_cs,
    output logic       busy
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned CS_W   = 2;
    localparam int unsigned REG_W  = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [CNT_W-1:0] PHASE_LD = CNT_W'(PHASE_TICKS);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_TICKS);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        GAP1 = 3'd2,
        DATA = 3'd3,
        GAP2 = 3'd4
    } state_t;

    state_t                        state_q;
    logic [CNT_W-1:0]              cnt_q;
    logic                          last_grant_q;
    logic [CS_W-1:0]               cs_q;
    logic [REG_W-1:0]              reg_q;
    logic [DATA_W-1:0]             data_q;
    logic [1:0]                    ack_q;
    logic                          bdir_q;
    logic                          bc1_q;
    logic [DATA_W-1:0]             din_q;
    logic                          busy_q;
    logic [CS_W-1:0]               valid_q;
    logic [CS_W-1:0][REG_W-1:0]    cache_q;

    logic [1:0]                    req_live;
    logic                          grant;
    logic [CS_W-1:0]               sel_cs;
    logic [REG_W-1:0]              sel_reg;
    logic [DATA_W-1:0]             sel_data;
    logic                          addr_hit;
    logic                          capture;
    logic                          phase_done;
    logic                          upd_en;
    logic [CS_W-1:0]               upd_cs;
    logic [REG_W-1:0]              upd_reg;

    // Arbitration, address-skip lookup and cache-update selection.
    always_comb begin
        // A requester being acked this cycle still shows its old req; mask it
        // so a write that stays in IDLE (cs = 00) is not captured twice.
        req_live = req & ~ack_q;
        grant    = 1'b0;
        case (req_live)
            2'b10:   grant = 1'b1;
            2'b11:   grant = ~last_grant_q;
            default: grant = 1'b0;
        endcase
        sel_cs   = grant ? req1_cs   : req0_cs;
        sel_reg  = grant ? req1_reg  : req0_reg;
        sel_data = grant ? req1_data : req0_data;

        // A clear in the capture cycle wins over the cached state.
        addr_hit = ~cache_clr;
        for (int i = 0; i < int'(CS_W); i++) begin
            if (sel_cs[i] && !(valid_q[i] && (cache_q[i] == sel_reg))) begin
                addr_hit = 1'b0;
            end
        end

        capture    = (state_q == IDLE) && (req_live != 2'b00);
        phase_done = clk_en && (cnt_q == CNT_W'(1));

        upd_en  = (capture && (sel_cs != '0) && addr_hit) ||
                  ((state_q == GAP1) && phase_done);
        upd_cs  = (state_q == IDLE) ? sel_cs  : cs_q;
        upd_reg = (state_q == IDLE) ? sel_reg : reg_q;
    end

    // Sequencer FSM with registered bus outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            cs_q         <= '0;
            reg_q        <= '0;
            data_q       <= '0;
            ack_q        <= '0;
            bdir_q       <= 1'b0;
            bc1_q        <= 1'b0;
            din_q        <= '0;
            busy_q       <= 1'b0;
        end else begin
            ack_q <= '0;
            // Transitions below override this with the next phase's load.
            if ((state_q != IDLE) && clk_en) begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    if (capture) begin
                        ack_q        <= grant ? 2'b10 : 2'b01;
                        last_grant_q <= grant;
                        if (sel_cs != '0) begin
                            cs_q   <= sel_cs;
                            reg_q  <= sel_reg;
                            data_q <= sel_data;
                            busy_q <= 1'b1;
                            cnt_q  <= PHASE_LD;
                            bdir_q <= 1'b1;
                            if (addr_hit) begin
                                state_q <= DATA;
                                bc1_q   <= 1'b0;
                                din_q   <= sel_data;
                            end else begin
                                state_q <= ADDR;
                                bc1_q   <= 1'b1;
                                din_q   <= {4'b0000, sel_reg};
                            end
                        end
                    end
                end
                ADDR: begin
                    if (phase_done) begin
                        state_q <= GAP1;
                        cnt_q   <= GAP_LD;
                        bdir_q  <= 1'b0;
                        bc1_q   <= 1'b0;
                    end
                end
                GAP1: begin
                    if (phase_done) begin
                        state_q <= DATA;
                        cnt_q   <= PHASE_LD;
                        bdir_q  <= 1'b1;
                        bc1_q   <= 1'b0;
                        din_q   <= data_q;
                    end
                end
                DATA: begin
                    if (phase_done) begin
                        state_q <= GAP2;
                        cnt_q   <= GAP_LD;
                        bdir_q  <= 1'b0;
                        bc1_q   <= 1'b0;
                    end
                end
                GAP2: begin
                    if (phase_done) begin
                        state_q <= IDLE;
                        cs_q    <= '0;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cs_q    <= '0;
                    bdir_q  <= 1'b0;
                    bc1_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Per-chip latched-address caches; a clear in the same cycle wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            cache_q <= '0;
        end else begin
            if (upd_en) begin
                for (int i = 0; i < int'(CS_W); i++) begin
                    if (upd_cs[i]) begin
                        valid_q[i] <= 1'b1;
                        cache_q[i] <= upd_reg;
                    end
                end
            end
            if (cache_clr) begin
                valid_q <= '0;
            end
        end
    end

    assign ack      = ack_q;
    assign psg_bdir = bdir_q;
    assign psg_bc1  = bc1_q;
    assign psg_din  = din_q;
    assign psg_cs   = cs_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_psg_write_sequencer.sv
// Directed bench for psg_write_sequencer: full and skipped writes, tie
// arbitration, clk_en pacing, cache clear, cs = 00 and reset mid-transaction.
// Observed word layout: {ack[1:0], busy, psg_cs[1:0], bdir, bc1, din[7:0]}.
module tb_psg_write_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clk_en = 1'b1;
    logic [1:0] req = 2'b00;
    logic [1:0] req0_cs = 2'b00;
    logic [1:0] req1_cs = 2'b00;
    logic [3:0] req0_reg = 4'h0;
    logic [3:0] req1_reg = 4'h0;
    logic [7:0] req0_data = 8'h00;
    logic [7:0] req1_data = 8'h00;
    logic       cache_clr = 1'b0;
    logic [1:0] ack;
    logic       psg_bdir;
    logic       psg_bc1;
    logic [7:0] psg_din;
    logic [1:0] psg_cs;
    logic       busy;

    int errors = 0;
    int checks = 0;

    logic        en_slow = 1'b0;
    int unsigned div = 0;

    psg_write_sequencer #(.PHASE_TICKS(2), .GAP_TICKS(1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clk_en    (clk_en),
        .req       (req),
        .req0_cs   (req0_cs),
        .req1_cs   (req1_cs),
        .req0_reg  (req0_reg),
        .req1_reg  (req1_reg),
        .req0_data (req0_data),
        .req1_data (req1_data),
        .ack       (ack),
        .cache_clr (cache_clr),
        .psg_bdir  (psg_bdir),
        .psg_bc1   (psg_bc1),
        .psg_din   (psg_din),
        .psg_cs    (psg_cs),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // clk_en settles 2 ns after each rising edge; slow mode ticks every 4th cycle.
    always @(posedge clk) begin
        #2;
        div = (div + 1) % 4;
        clk_en = en_slow ? (div == 0) : 1'b1;
    end

    logic [14:0] obs;
    assign obs = {ack, busy, psg_cs, psg_bdir, psg_bc1, psg_din};

    function automatic logic [14:0] w(input logic [1:0] a, input logic b,
                                      input logic [1:0] cs, input logic [1:0] bb,
                                      input logic [7:0] d);
        return {a, b, cs, bb, d};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req = 2'b00;
        cache_clr = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL reset_asserted got=%h exp=%h", obs, 15'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL reset_released got=%h exp=%h", obs, 15'h0);
        end
    endtask

    task automatic test_single_write();
        logic [14:0] exp [7];
        exp = '{w(2'b01,1,2'b01,2'b11,8'h07), w(2'b00,1,2'b01,2'b11,8'h07),
                w(2'b00,1,2'b01,2'b00,8'h07), w(2'b00,1,2'b01,2'b10,8'h38),
                w(2'b00,1,2'b01,2'b10,8'h38), w(2'b00,1,2'b01,2'b00,8'h38),
                w(2'b00,0,2'b00,2'b00,8'h38)};
        req0_cs = 2'b01; req0_reg = 4'h7; req0_data = 8'h38; req = 2'b01;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp[k]) begin
                errors++;
                $display("FAIL single[%0d] got=%h exp=%h", k, obs, exp[k]);
            end
            if (k == 0) req = 2'b00;
        end
    endtask

    task automatic test_addr_skip();
        logic [14:0] exp_a [4];
        logic [14:0] exp_b [7];
        exp_a = '{w(2'b01,1,2'b01,2'b10,8'h3F), w(2'b00,1,2'b01,2'b10,8'h3F),
                  w(2'b00,1,2'b01,2'b00,8'h3F), w(2'b00,0,2'b00,2'b00,8'h3F)};
        exp_b = '{w(2'b01,1,2'b11,2'b11,8'h07), w(2'b00,1,2'b11,2'b11,8'h07),
                  w(2'b00,1,2'b11,2'b00,8'h07), w(2'b00,1,2'b11,2'b10,8'h55),
                  w(2'b00,1,2'b11,2'b10,8'h55), w(2'b00,1,2'b11,2'b00,8'h55),
                  w(2'b00,0,2'b00,2'b00,8'h55)};
        req0_cs = 2'b01; req0_reg = 4'h7; req0_data = 8'h3F; req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_a[k]) begin
                errors++;
                $display("FAIL skip[%0d] got=%h exp=%h", k, obs, exp_a[k]);
            end
            if (k == 0) req = 2'b00;
        end
        req0_cs = 2'b11; req0_reg = 4'h7; req0_data = 8'h55; req = 2'b01;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== exp_b[k]) begin
                errors++;
                $display("FAIL skip_both_chips[%0d] got=%h exp=%h", k, obs, exp_b[k]);
            end
            if (k == 0) req = 2'b00;
        end
    endtask

    task automatic test_back_to_back_tie();
        logic [1:0] exp_ack;
        do_reset();
        req0_cs = 2'b01; req0_reg = 4'h1; req0_data = 8'h11;
        req1_cs = 2'b10; req1_reg = 4'h2; req1_data = 8'h22;
        req = 2'b11;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            case (k)
                1, 15, 23: exp_ack = 2'b01;
                8, 19:     exp_ack = 2'b10;
                default:   exp_ack = 2'b00;
            endcase
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL tie_ack[cycle %0d] got=%b exp=%b", k, ack, exp_ack);
            end
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL tie_drain_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_clk_en_pacing();
        logic [14:0] exp;
        bit          found;
        do_reset();
        en_slow = 1'b1;
        found = 1'b0;
        for (int t = 0; t < 8 && !found; t++) begin
            @(negedge clk);
            if (clk_en === 1'b1) found = 1'b1;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL clk_en_wait got=timeout exp=tick within 8 cycles");
        end
        req0_cs = 2'b01; req0_reg = 4'h3; req0_data = 8'hA5; req = 2'b01;
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            if (k <= 8)       exp = w((k == 1) ? 2'b01 : 2'b00, 1, 2'b01, 2'b11, 8'h03);
            else if (k <= 12) exp = w(2'b00, 1, 2'b01, 2'b00, 8'h03);
            else if (k <= 20) exp = w(2'b00, 1, 2'b01, 2'b10, 8'hA5);
            else if (k <= 24) exp = w(2'b00, 1, 2'b01, 2'b00, 8'hA5);
            else              exp = w(2'b00, 0, 2'b00, 2'b00, 8'hA5);
            checks++;
            if (obs !== exp) begin
                errors++;
                $display("FAIL clk_en_slow[cycle %0d] got=%h exp=%h", k, obs, exp);
            end
            if (k == 1) req = 2'b00;
        end
        en_slow = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_cache_clr_and_cs0();
        // PSG1 has register 3 latched from the previous test.
        req0_cs = 2'b01; req0_reg = 4'h3; req0_data = 8'h5A; req = 2'b01;
        cache_clr = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== w(2'b01, 1, 2'b01, 2'b11, 8'h03)) begin
            errors++;
            $display("FAIL clr_at_capture got=%h exp=%h", obs, w(2'b01, 1, 2'b01, 2'b11, 8'h03));
        end
        cache_clr = 1'b0;
        req = 2'b00;
        repeat (6) @(negedge clk);
        checks++;
        if (obs !== w(2'b00, 0, 2'b00, 2'b00, 8'h5A)) begin
            errors++;
            $display("FAIL clr_txn_end got=%h exp=%h", obs, w(2'b00, 0, 2'b00, 2'b00, 8'h5A));
        end
        req1_cs = 2'b00; req1_reg = 4'h5; req1_data = 8'h77; req = 2'b10;
        @(negedge clk);
        checks++;
        if (obs !== w(2'b10, 0, 2'b00, 2'b00, 8'h5A)) begin
            errors++;
            $display("FAIL cs0_ack got=%h exp=%h", obs, w(2'b10, 0, 2'b00, 2'b00, 8'h5A));
        end
        req = 2'b00;
        @(negedge clk);
        checks++;
        if (obs !== w(2'b00, 0, 2'b00, 2'b00, 8'h5A)) begin
            errors++;
            $display("FAIL cs0_quiet got=%h exp=%h", obs, w(2'b00, 0, 2'b00, 2'b00, 8'h5A));
        end
        // Cache must still hold PSG1 reg 3 from the DATA entry above.
        req0_cs = 2'b01; req0_reg = 4'h3; req0_data = 8'h66; req = 2'b01;
        @(negedge clk);
        checks++;
        if (obs !== w(2'b01, 1, 2'b01, 2'b10, 8'h66)) begin
            errors++;
            $display("FAIL cs0_cache_kept got=%h exp=%h", obs, w(2'b01, 1, 2'b01, 2'b10, 8'h66));
        end
        req = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== w(2'b00, 0, 2'b00, 2'b00, 8'h66)) begin
            errors++;
            $display("FAIL cs0_skip_end got=%h exp=%h", obs, w(2'b00, 0, 2'b00, 2'b00, 8'h66));
        end
    endtask

    task automatic test_reset_mid_data();
        req0_cs = 2'b01; req0_reg = 4'h9; req0_data = 8'h99; req = 2'b01;
        @(negedge clk);
        req = 2'b00;
        repeat (3) @(negedge clk);
        checks++;
        if (obs !== w(2'b00, 1, 2'b01, 2'b10, 8'h99)) begin
            errors++;
            $display("FAIL rst_pre_data got=%h exp=%h", obs, w(2'b00, 1, 2'b01, 2'b10, 8'h99));
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL rst_mid_data got=%h exp=%h", obs, 15'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 15'h0) begin
            errors++;
            $display("FAIL rst_no_resume got=%h exp=%h", obs, 15'h0);
        end
        req0_cs = 2'b01; req0_reg = 4'h9; req0_data = 8'h42; req = 2'b01;
        @(negedge clk);
        checks++;
        if (obs !== w(2'b01, 1, 2'b01, 2'b11, 8'h09)) begin
            errors++;
            $display("FAIL rst_full_addr got=%h exp=%h", obs, w(2'b01, 1, 2'b01, 2'b11, 8'h09));
        end
        req = 2'b00;
        repeat (6) @(negedge clk);
        checks++;
        if (obs !== w(2'b00, 0, 2'b00, 2'b00, 8'h42)) begin
            errors++;
            $display("FAIL rst_txn_end got=%h exp=%h", obs, w(2'b00, 0, 2'b00, 2'b00, 8'h42));
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single_write();
        test_addr_skip();
        test_back_to_back_tie();
        test_clk_en_pacing();
        test_cache_clr_and_cs0();
        test_reset_mid_data();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=bench completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/psg_write_sequencer.md
# psg_write_sequencer

Sequences AY-3-8910-style register writes onto the bus of one or two jt49_bus PSG instances. Two requesters share the PSG bus, for example the CPU I/O decoder and a cartridge or preset loader. Each requester hands over one (chip-select, register, data) write with a req/ack handshake. The block arbitrates round-robin, generates the address-latch and data-write phases on bdir/bc1 paced by clk_en, and skips the address phase when the target chip already has that register latched.

## Interface
Parameters:
- PHASE_TICKS, 2: clk_en ticks each active bus phase (ADDR, DATA) is held; legal range 1..15.
- GAP_TICKS, 1: clk_en ticks of the inactive gap after each active phase; legal range 1..15.

Ports:
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset; asynchronous, active-low.
- clk_en  in  1  PSG clock enable; all phase timing counts these ticks.
- req  in  2  per-requester write request; index 0 and index 1.
- req0_cs, req1_cs  in  2 each  target chips; bit0 = PSG1, bit1 = PSG2.
- req0_reg, req1_reg  in  4 each  PSG register number.
- req0_data, req1_data  in  8 each  register data.
- ack  out  2  one-cycle capture pulse per requester.
- cache_clr  in  1  synchronous; invalidates both latched-address caches (drive from PSG reset).
- psg_bdir  out  1  PSG BDIR; the integrator ANDs it with psg_cs per chip.
- psg_bc1  out  1  PSG BC1; the integrator ANDs it with psg_cs per chip.
- psg_din  out  8  PSG data/address bus.
- psg_cs  out  2  chips addressed by the current transaction.
- busy  out  1  high whenever the FSM is not in IDLE.

## Operation
- FSM states: IDLE, ADDR, GAP1, DATA, GAP2.
- IDLE, capture:
  - On any clk edge with req != 0, pick the winner.
  - Only one requesting: that one wins.
  - Both requesting: the one that is not last_grant wins.
  - Capture the winner's cs/reg/data, set last_grant to the winner, and pulse ack[winner] in the following cycle.
- Handshake rules:
  - The requester holds its fields stable while req is high.
  - After seeing ack, the requester may drop req or present the next write.
  - A req still high during the ack cycle is not re-captured; the FSM has already left IDLE.
- Captured cs = 00: ack is given, the FSM stays in IDLE, there is no bus activity and the caches are unchanged.
- Address skip:
  - Each chip has a cache: valid bit plus 4-bit register.
  - The ADDR and GAP1 phases are skipped (capture goes directly to DATA) only if every chip in cs has valid = 1 and a cached register equal to reg.
  - Otherwise capture goes to ADDR.
- Per-state outputs:
  - ADDR: bdir=1, bc1=1, din={4'b0, reg}.
  - GAP1 and GAP2: bdir=0, bc1=0, din holds its last value.
  - DATA: bdir=1, bc1=0, din=data.
- psg_cs: equals the captured cs from capture until GAP2 exits; 00 in IDLE.
- Cache update: on entry to DATA, every chip in cs gets valid=1 and its cache set to reg.
- cache_clr:
  - Clears both valid bits.
  - If it is asserted in the same cycle as a capture, the clear wins: the skip check sees invalid caches and ADDR is performed.
  - If it is asserted mid-transaction, the transaction completes and the cache update on DATA entry still applies; a clear in that same cycle wins.

## Timing
- Phase counter:
  - Loaded with PHASE_TICKS or GAP_TICKS on state entry.
  - Decremented on each clk_en.
  - The state exits on the clk edge where clk_en=1 and the counter is 1.
  - A clk_en in the entry cycle itself does not count.
- Transaction length: with clk_en every cycle and defaults, a full transaction is ADDR 2 + GAP1 1 + DATA 2 + GAP2 1 = 6 cycles after capture. A skipped transaction is 3 cycles.
- Back-to-back: IDLE lasts at least one cycle between transactions; the next capture happens on the first edge in IDLE.
- clk_en low stretches the current phase indefinitely; outputs stay stable.
- Reset values (also on asynchronous reset mid-transaction):
  - State IDLE.
  - ack=00, psg_bdir=0, psg_bc1=0, psg_din=00, psg_cs=00, busy=0.
  - Caches invalid, last_grant=1, so requester 0 wins the first tie.
  - No partial bus cycle resumes after reset release.

## Test plan
- Single write, clk_en=1: req0 with cs=01, reg=7, data=0x38 -> ack[0] one cycle; bdir/bc1=11 with din=0x07 for 2 cycles, 00 for 1, 10 with din=0x38 for 2, 00 for 1; busy high for 6 cycles.
- Address skip: repeat reg=7 data=0x3F to cs=01 -> no ADDR phase, DATA then GAP2 only. Then cs=11 with reg=7 -> ADDR performed because PSG2's cache is invalid.
- Tie arbitration: both req held continuously after reset -> grants alternate 0,1,0,1; each ack is exactly one cycle, and there are no double captures.
- clk_en every 4th cycle, PHASE_TICKS=2 -> each active phase spans 8 clk cycles, and outputs are stable between ticks.
- cache_clr in the same cycle as the capture of a cached register -> ADDR phase present. cs=00 request -> ack with no bus activity and busy stays 0.
- rst_n pulled low during DATA -> all outputs 0 immediately; after release, a write to the previously cached register performs a full ADDR phase.
